// File: rtl/sgb_packet_tx.sv
// Serialises a 16-byte SGB command packet onto {P15,P14}, owning the lines while busy and passing the CPU through when idle.
// Latency: start to done is RESET+HIGH+129*(LOW+HIGH) ce ticks; there is no backpressure, and start/wr_en are ignored while busy.
module sgb_packet_tx #(
  parameter int RESET_TICKS = 8,
  parameter int LOW_TICKS   = 4,
  parameter int HIGH_TICKS  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] cpu_p54,
  output logic       busy,
  output logic       done,
  output logic [1:0] joy_p54
);

  typedef enum logic [2:0] {
    IDLE, RST_LO, RST_HI, BIT_LO, BIT_HI, STOP_LO, STOP_HI
  } state_t;

  localparam logic [7:0] RST_END  = 8'(RESET_TICKS - 1);
  localparam logic [7:0] LOW_END  = 8'(LOW_TICKS - 1);
  localparam logic [7:0] HIGH_END = 8'(HIGH_TICKS - 1);

  state_t     state;
  logic [7:0] tick;
  logic [6:0] bit_idx;
  logic [1:0] p54_q;
  logic [7:0] pkt_buf [16];

  logic [7:0] ph_last;
  logic       phase_end;
  logic [6:0] bit_nxt;
  logic       bit_val;
  logic [1:0] bit_lvl;

  always_comb begin
    ph_last = 8'd0;
    case (state)
      RST_LO:                   ph_last = RST_END;
      RST_HI, BIT_HI, STOP_HI:  ph_last = HIGH_END;
      BIT_LO, STOP_LO:          ph_last = LOW_END;
      default:                  ph_last = 8'd0;
    endcase
  end

  assign phase_end = ce && (tick == ph_last);

  // Bit that the next BIT_LO will carry: 0 after the reset pulse, b+1 after a bit.
  always_comb begin
    bit_nxt = (state == BIT_HI) ? bit_idx + 7'd1 : 7'd0;
    bit_val = pkt_buf[bit_nxt[6:3]][bit_nxt[2:0]];
    bit_lvl = bit_val ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      tick    <= 8'd0;
      bit_idx <= 7'd0;
      p54_q   <= 2'b11;
      for (int i = 0; i < 16; i++) pkt_buf[i] <= 8'd0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (wr_en) pkt_buf[wr_addr] <= wr_data;
        if (start) begin
          state   <= RST_LO;
          busy    <= 1'b1;
          tick    <= 8'd0;
          bit_idx <= 7'd0;
          p54_q   <= 2'b00;
        end
      end else if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        tick  <= 8'd0;
        p54_q <= 2'b11;
      end else if (ce) begin
        if (!phase_end) begin
          tick <= tick + 8'd1;
        end else begin
          tick <= 8'd0;
          case (state)
            RST_LO: begin
              state <= RST_HI;
              p54_q <= 2'b11;
            end
            RST_HI: begin
              state <= BIT_LO;
              p54_q <= bit_lvl;
            end
            BIT_LO: begin
              state <= BIT_HI;
              p54_q <= 2'b11;
            end
            BIT_HI: begin
              if (bit_idx == 7'd127) begin
                state <= STOP_LO;
                p54_q <= 2'b10;
              end else begin
                state   <= BIT_LO;
                bit_idx <= bit_nxt;
                p54_q   <= bit_lvl;
              end
            end
            STOP_LO: begin
              state <= STOP_HI;
              p54_q <= 2'b11;
            end
            STOP_HI: begin
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              bit_idx <= 7'd0;
              p54_q   <= 2'b11;
            end
            default: begin
              state <= IDLE;
              busy  <= 1'b0;
              p54_q <= 2'b11;
            end
          endcase
        end
      end
    end
  end

  assign joy_p54 = busy ? p54_q : cpu_p54;

endmodule
